// File: rtl/bias_activation_unit.sv
// Post-accumulator vector stage: per-column bias add with saturation, then
// optional leaky ReLU. Two-stage pipeline without backpressure. Row and column
// counters track tile position, and done marks the last element of each tile.
module bias_activation_unit #(
  parameter int NUM_COLS = 2,
  parameter int NUM_ROWS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bias_wr_en,
  input  logic [7:0]  bias_wr_addr,
  input  logic [15:0] bias_wr_data,
  input  logic        act_enable,
  input  logic [15:0] leak_factor,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [7:0]  out_col,
  output logic        done
);

  // Widths are at least 1 bit so single-column or single-row tiles still work.
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  // The bias store is padded to a power of two. The padding entries are never
  // written and never addressed by the column counter.
  localparam int DEPTH = 1 << COL_W;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(NUM_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(NUM_ROWS - 1);

  logic [15:0]      bias_mem [DEPTH];
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             col_last;
  logic             row_last;
  logic             bias_wr_hit;

  logic [15:0]        bias_rd;
  logic signed [16:0] sum17;
  logic [15:0]        sum_sat;

  logic             s1_valid;
  logic [15:0]      s1_data;
  logic [COL_W-1:0] s1_col;
  logic             s1_last;

  logic signed [31:0] prod;
  logic signed [31:0] prod_shr;
  logic [15:0]        leaky_sat;
  logic [15:0]        act_res;

  assign col_last    = (col_cnt == COL_MAX);
  assign row_last    = (row_cnt == ROW_MAX);
  assign bias_wr_hit = bias_wr_en && ({1'b0, bias_wr_addr} < 9'(NUM_COLS));

  // Bias store. A write lands on the edge, so a read of the same index in the
  // same cycle still sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bias_mem[i] <= '0;
      end
    end else if (bias_wr_hit) begin
      bias_mem[bias_wr_addr[COL_W-1:0]] <= bias_wr_data;
    end
  end

  // Tile position counters advance only on accepted inputs and wrap at the
  // tile end, so the next tile starts without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (in_valid) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_last ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Stage 1 combinational: 17-bit bias add clamped to the Q8.8 range.
  always_comb begin
    bias_rd = bias_mem[col_cnt];
    sum17   = $signed({in_data[15], in_data}) + $signed({bias_rd[15], bias_rd});
    sum_sat = sum17[15:0];
    if (!sum17[16] && sum17[15]) begin
      sum_sat = 16'h7FFF;
    end else if (sum17[16] && !sum17[15]) begin
      sum_sat = 16'h8000;
    end
  end

  // Stage 1 register: biased value plus column tag and tile-end flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_col   <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_data  <= in_valid ? sum_sat : '0;
      s1_col   <= in_valid ? col_cnt : '0;
      s1_last  <= in_valid && col_last && row_last;
    end
  end

  // Stage 2 combinational: Q8.8 multiply by the leak slope. The arithmetic
  // shift floors toward -inf, and the result is clamped to 16 bits. A negative
  // slope can make the product positive, so both clamp directions are checked.
  always_comb begin
    prod      = $signed({{16{s1_data[15]}}, s1_data}) *
                $signed({{16{leak_factor[15]}}, leak_factor});
    prod_shr  = prod >>> 8;
    leaky_sat = prod_shr[15:0];
    if (prod_shr > 32'sd32767) begin
      leaky_sat = 16'h7FFF;
    end else if (prod_shr < -32'sd32768) begin
      leaky_sat = 16'h8000;
    end
    act_res = (act_enable && s1_data[15]) ? leaky_sat : s1_data;
  end

  // Output register. Data and column are forced to zero on bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_col   <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      out_data  <= s1_valid ? act_res : '0;
      out_col   <= s1_valid ? 8'(s1_col) : 8'd0;
      done      <= s1_valid && s1_last;
    end
  end

endmodule

// File: tb/tb_bias_activation_unit.sv
// Self-checking bench for bias_activation_unit with the default 2x2 tile.
// Expected results are queued as stimulus is driven and are popped as outputs
// appear.
module tb_bias_activation_unit;

  logic        clk;
  logic        rst;
  logic        bias_wr_en;
  logic [7:0]  bias_wr_addr;
  logic [15:0] bias_wr_data;
  logic        act_enable;
  logic [15:0] leak_factor;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic [7:0]  out_col;
  logic        done;

  bias_activation_unit #(.NUM_COLS(2), .NUM_ROWS(2)) dut (
    .clk(clk), .rst(rst),
    .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
    .act_enable(act_enable), .leak_factor(leak_factor),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_col(out_col), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  col;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;
  int   m_col    = 0;
  int   m_row    = 0;
  bit   mon_en   = 1'b0;

  // Output monitor: pops one expectation per valid output and checks that
  // bubbles read back as all zeros.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (done === 1'b1) done_cnt++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got data=%h col=%0d done=%b, required no output", out_data, out_col, done);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_data !== e.data || out_col !== e.col || done !== e.last) begin
            errors++;
            $display("FAIL output: got data=%h col=%0d done=%b, required data=%h col=%0d done=%b",
                     out_data, out_col, done, e.data, e.col, e.last);
          end
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_col !== 8'h0 || done !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: got valid=%b data=%h col=%0d done=%b, required all 0",
                   out_valid, out_data, out_col, done);
        end
      end
    end
  end

  // The following tasks are all entered just after a rising edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] exp_d);
    exp_t e;
    e.data = exp_d;
    e.col  = 8'(m_col);
    e.last = (m_col == 1) && (m_row == 1);
    sb.push_back(e);
    if (m_col == 1) begin
      m_col = 0;
      m_row = (m_row == 1) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'h0;
  endtask

  task automatic wr_bias(input logic [7:0] a, input logic [15:0] d);
    bias_wr_en   = 1'b1;
    bias_wr_addr = a;
    bias_wr_data = d;
    @(posedge clk);
    #1;
    bias_wr_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_col = 0;
    m_row = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outputs still pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    // A bias write held during reset must be ignored.
    bias_wr_en   = 1'b1;
    bias_wr_addr = 8'd0;
    bias_wr_data = 16'h1234;
    apply_reset();
    bias_wr_en = 1'b0;
    mon_en = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_col !== 8'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h col=%0d done=%b, required all 0",
               out_valid, out_data, out_col, done);
    end
    send(16'h0000, 16'h0000);
    drain();
  endtask

  task automatic test_latency();
    apply_reset();
    send(16'h0042, 16'h0042);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got out_valid=%b one edge after sampling, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_on_time: got out_valid=%b two edges after sampling, required 1", out_valid);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_bias_add();
    apply_reset();
    wr_bias(8'd0, 16'h0100);
    wr_bias(8'd1, 16'hFF00);
    send(16'h0200, 16'h0300);
    send(16'h0080, 16'hFF80);
    drain();
  endtask

  task automatic test_leaky();
    apply_reset();
    act_enable  = 1'b1;
    leak_factor = 16'h0040;
    send(16'hFC00, 16'hFF00);
    send(16'h0300, 16'h0300);
    send(16'hFFFF, 16'hFFFF);
    drain();
    idle(2);
    act_enable = 1'b0;
  endtask

  task automatic test_saturation();
    apply_reset();
    wr_bias(8'd0, 16'h0200);
    wr_bias(8'd1, 16'hFE00);
    send(16'h7F00, 16'h7FFF);
    send(16'h8100, 16'h8000);
    drain();
  endtask

  task automatic test_tile_done();
    int d0;
    apply_reset();
    wr_bias(8'd0, 16'h0010);
    wr_bias(8'd1, 16'h0020);
    d0 = done_cnt;
    send(16'h0100, 16'h0110);
    idle(1);
    send(16'h0200, 16'h0220);
    idle(1);
    send(16'h0300, 16'h0310);
    idle(1);
    send(16'h0400, 16'h0420);
    idle(1);
    send(16'h0500, 16'h0510);
    drain();
    idle(2);
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL tile_done_count: got %0d done pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_tile();
    int d0;
    apply_reset();
    send(16'h0100, 16'h0100);
    send(16'h0200, 16'h0200);
    send(16'h0300, 16'h0300);
    apply_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_col !== 8'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got valid=%b data=%h col=%0d done=%b, required all 0",
               out_valid, out_data, out_col, done);
    end
    idle(5);
    d0 = done_cnt;
    send(16'h0001, 16'h0001);
    send(16'h0002, 16'h0002);
    send(16'h0003, 16'h0003);
    send(16'h0004, 16'h0004);
    drain();
    idle(2);
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL midreset_done_count: got %0d done pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_write_collision();
    apply_reset();
    wr_bias(8'd0, 16'h0100);
    bias_wr_en   = 1'b1;
    bias_wr_addr = 8'd0;
    bias_wr_data = 16'h0500;
    send(16'h0000, 16'h0100);
    bias_wr_en = 1'b0;
    wr_bias(8'd5, 16'h7000);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h0500);
    drain();
  endtask

  initial begin
    rst          = 1'b1;
    bias_wr_en   = 1'b0;
    bias_wr_addr = 8'd0;
    bias_wr_data = 16'h0;
    act_enable   = 1'b0;
    leak_factor  = 16'h0;
    in_valid     = 1'b0;
    in_data      = 16'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_bias_add();
    test_leaky();
    test_saturation();
    test_tile_done();
    test_reset_mid_tile();
    test_write_collision();
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
